// File: rtl/bist_pkg.sv
// Shared state encoding, MISR geometry and MISR next-state helper for the
// s9234 scan BIST sequencer / signature analyser.
package bist_pkg;

    localparam int MISR_W = 7;
    localparam logic [MISR_W-1:0] MISR_TAPS = 7'b1100000;
    localparam int PCNT_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        UNLOAD  = 3'd4,
        DONE    = 3'd5
    } bist_state_e;

    // One MISR step for x^7+x^6+1: bit 0 takes the feedback, bit 6 folds in the x^6 tap.
    function automatic logic [MISR_W-1:0] misr_next(
        input logic [MISR_W-1:0] q,
        input logic [MISR_W-1:0] d
    );
        logic [MISR_W-1:0] n;
        n[0]            = q[MISR_W-1] ^ d[0];
        n[MISR_W-2:1]   = q[MISR_W-3:0] ^ d[MISR_W-2:1];
        n[MISR_W-1]     = (^(q & MISR_TAPS)) ^ d[MISR_W-1];
        return n;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// 7-bit multiple-input signature register compacting the seven scan-out chains.
module bist_misr
    import bist_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [MISR_W-1:0] d,
    output logic [MISR_W-1:0] q
);

    logic [MISR_W-1:0] r_q;

    // Signature register: clear wins over compaction, hold when not enabled.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= misr_next(r_q, d);
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/bist_sig_analyzer.sv
// BIST sequencer and signature analyser for the s9234 scan BIST wrapper.
// Optional feature macro: BIST_SIG_ABORT_EN adds an 'abort' input.
module bist_sig_analyzer
    import bist_pkg::*;
#(
    parameter int                CHAIN_LEN    = 33,
    parameter int                NUM_PATTERNS = 100,
    parameter logic [MISR_W-1:0] GOLDEN_SIG   = 7'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef BIST_SIG_ABORT_EN
    input  logic              abort,
`endif
    input  logic [MISR_W-1:0] so,
    output logic              scan_en,
    output logic              bist_en,
    output logic              tpg_reset,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature,
    output logic [PCNT_W-1:0] pattern_cnt
);

    localparam int                SCNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(CHAIN_LEN - 1);
    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
    localparam logic [PCNT_W:0]   NPAT      = (PCNT_W + 1)'(NUM_PATTERNS);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

    bist_state_e       r_state;
    logic [SCNT_W-1:0] r_shift_cnt;
    logic [PCNT_W-1:0] r_pattern_cnt;
    logic              r_scan_en;
    logic              r_bist_en;
    logic              r_tpg_reset;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;

    logic              w_run_start;
    logic              w_abort;
    logic              w_misr_en;
    logic              w_more_patterns;
    logic [MISR_W-1:0] w_sig;

`ifdef BIST_SIG_ABORT_EN
    assign w_abort = abort & r_busy;
`else
    assign w_abort = 1'b0;
`endif

    assign w_run_start     = ((r_state == IDLE) || (r_state == DONE)) && start;
    assign w_more_patterns = (({1'b0, r_pattern_cnt} + (PCNT_W + 1)'(1)) < NPAT);

    // The first shift-in holds uninitialised core state, so compaction waits for a capture.
    assign w_misr_en = !w_abort &&
                       (((r_state == SHIFT) && (r_pattern_cnt != '0)) || (r_state == UNLOAD));

    // Sequencer: state, shift/pattern counters and registered control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_shift_cnt   <= '0;
            r_pattern_cnt <= '0;
            r_scan_en     <= 1'b0;
            r_bist_en     <= 1'b0;
            r_tpg_reset   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
        end else if (w_abort) begin
            r_state     <= DONE;
            r_shift_cnt <= '0;
            r_scan_en   <= 1'b0;
            r_bist_en   <= 1'b0;
            r_tpg_reset <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_aborted   <= 1'b1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state       <= INIT;
                        r_shift_cnt   <= '0;
                        r_pattern_cnt <= '0;
                        r_scan_en     <= 1'b0;
                        r_bist_en     <= 1'b1;
                        r_tpg_reset   <= 1'b1;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_aborted     <= 1'b0;
                    end
                end
                INIT: begin
                    r_state     <= SHIFT;
                    r_tpg_reset <= 1'b0;
                    r_scan_en   <= 1'b1;
                end
                SHIFT: begin
                    if (r_shift_cnt == SCNT_LAST) begin
                        r_state     <= CAPTURE;
                        r_shift_cnt <= '0;
                        r_scan_en   <= 1'b0;
                    end else begin
                        r_shift_cnt <= r_shift_cnt + SCNT_ONE;
                    end
                end
                CAPTURE: begin
                    r_pattern_cnt <= r_pattern_cnt + PCNT_ONE;
                    r_scan_en     <= 1'b1;
                    if (w_more_patterns) begin
                        r_state <= SHIFT;
                    end else begin
                        r_state <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (r_shift_cnt == SCNT_LAST) begin
                        r_state     <= DONE;
                        r_shift_cnt <= '0;
                        r_scan_en   <= 1'b0;
                        r_bist_en   <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_shift_cnt <= r_shift_cnt + SCNT_ONE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_shift_cnt <= '0;
                    r_scan_en   <= 1'b0;
                    r_bist_en   <= 1'b0;
                    r_tpg_reset <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_aborted   <= 1'b0;
                end
            endcase
        end
    end

    bist_misr u_misr (
        .clk   (clk),
        .reset (reset),
        .clear (w_run_start),
        .en    (w_misr_en),
        .d     (so),
        .q     (w_sig)
    );

    assign scan_en     = r_scan_en;
    assign bist_en     = r_bist_en;
    assign tpg_reset   = r_tpg_reset;
    assign busy        = r_busy;
    assign done        = r_done;
    assign signature   = w_sig;
    assign pattern_cnt = r_pattern_cnt;
    assign pass        = r_done & ~r_aborted & (w_sig == GOLDEN_SIG);

endmodule
